// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder, STAGE_W bits per stage with ripple carry between stages; optional subtract via `PIPE_ADD_SUB_EN.
// Latency WIDTH/STAGE_W cycles, one result per cycle; the whole pipe freezes when the output is held (in_ready = advance).
module pipelined_adder #(
    parameter int WIDTH   = 128,
    parameter int STAGE_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / STAGE_W;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % STAGE_W != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGE_W");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPE_ADD_SUB_EN
    // Subtract as A + ~B + 1; carry_out = 1 then means no borrow.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = carry_in ^ sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = carry_in;
`endif

    // Per-stage inputs (from ports or the previous stage) and registered state.
    logic [WIDTH-1:0]   a_in   [STAGES];
    logic [WIDTH-1:0]   b_in   [STAGES];
    logic [WIDTH-1:0]   acc_in [STAGES];
    logic               cin_in [STAGES];
    logic               vld_in [STAGES];
    logic [STAGE_W:0]   s_csum [STAGES];
    logic [WIDTH-1:0]   s_a    [STAGES];
    logic [WIDTH-1:0]   s_b    [STAGES];
    logic [WIDTH-1:0]   s_acc  [STAGES];
    logic               s_carry[STAGES];
    logic               s_vld  [STAGES];

    assign advance  = !s_vld[LAST] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_q;
        logic             carry_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] acc_q;
        logic [WIDTH-1:0] acc_d;

        if (k == 0) begin : g_first
            assign a_in[k]   = a;
            assign b_in[k]   = b_eff;
            assign cin_in[k] = cin_eff;
            assign vld_in[k] = in_valid;
            assign acc_in[k] = '0;
        end else begin : g_next
            assign a_in[k]   = s_a[k-1];
            assign b_in[k]   = s_b[k-1];
            assign cin_in[k] = s_carry[k-1];
            assign vld_in[k] = s_vld[k-1];
            assign acc_in[k] = s_acc[k-1];
        end

        assign s_csum[k] = {1'b0, a_in[k][k*STAGE_W +: STAGE_W]}
                         + {1'b0, b_in[k][k*STAGE_W +: STAGE_W]}
                         + {{STAGE_W{1'b0}}, cin_in[k]};

        always_comb begin
            acc_d                      = acc_in[k];
            acc_d[k*STAGE_W +: STAGE_W] = s_csum[k][STAGE_W-1:0];
        end

        // Data only loads behind a valid token so outputs hold across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                a_q     <= '0;
                b_q     <= '0;
                acc_q   <= '0;
            end else if (advance) begin
                vld_q <= vld_in[k];
                if (vld_in[k]) begin
                    carry_q <= s_csum[k][STAGE_W];
                    a_q     <= a_in[k];
                    b_q     <= b_in[k];
                    acc_q   <= acc_d;
                end
            end
        end

        assign s_vld[k]   = vld_q;
        assign s_carry[k] = carry_q;
        assign s_a[k]     = a_q;
        assign s_b[k]     = b_q;
        assign s_acc[k]   = acc_q;
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_csum[LAST][STAGE_W-1])
                 ^ s_csum[LAST][STAGE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance && vld_in[LAST]) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = s_vld[LAST];
    assign sum       = s_acc[LAST];
    assign carry_out = s_carry[LAST];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases plus randomized traffic against a full-precision arithmetic model.
module tb_pipelined_adder;

    localparam int W = 128;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    res_t exp_q[$];
    res_t last_res;
    res_t held;
    logic held_vld = 1'b0;

    pipelined_adder #(.WIDTH(W), .STAGE_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .carry_in  (op_cin),
        .sub       (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        res_t         r;
        be = b;
        ce = cin;
`ifdef PIPE_ADD_SUB_EN
        if (s) begin
            be = ~b;
            ce = ~cin;
        end
`endif
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        r.s  = full[W-1:0];
        r.co = full[W];
        r.ov = (a[W-1] == be[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    // Scoreboard: evaluated mid-cycle, so handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (held_vld && out_valid) begin
                check("hold_sum", sum, held.s);
                check("hold_co", carry_out, held.co);
                check("hold_ov", overflow, held.ov);
            end
            held_vld = out_valid && !out_ready;
            held     = {sum, carry_out, overflow};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e.s);
                    check("carry_out", carry_out, e.co);
                    check("overflow", overflow, e.ov);
                    last_res = {sum, carry_out, overflow};
                    rx_cnt++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(op_a, op_b, op_cin, op_sub));
        end else begin
            held_vld = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
        int waited;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = s;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int rx0;
        logic [W-1:0] ones;
        ones     = '1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_overflow", overflow, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry ripples from chunk 0 into chunk 1; first result after exactly 4 cycles.
        send(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        drain();
        check("t1_sum", last_res.s, 128'h1_0000_0000);
        check("t1_co", last_res.co, 0);

        send(ones, 128'd1, 1'b0, 1'b0);
        drain();
        check("t2_sum", last_res.s, 0);
        check("t2_co", last_res.co, 1);
        check("t2_ov", last_res.ov, 0);

        send({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
        drain();
        check("t3_sum", last_res.s, {1'b1, {(W-1){1'b0}}});
        check("t3_ov", last_res.ov, 1);
        check("t3_co", last_res.co, 0);

        // Back-to-back traffic under random backpressure.
        rdy_mode = 1;
        rx0 = rx_cnt;
        for (int i = 0; i < 8; i++) send(W'(i), W'(i) << 96, 1'b0, 1'b0);
        drain();
        check("b2b_count", rx_cnt - rx0, 8);
        check("b2b_last", last_res.s, (W'(7) << 96) | W'(7));

        // Randomized operands, gaps and backpressure.
        rx0 = rx_cnt;
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = ones;
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        check("rand_count", rx_cnt - rx0, 200);

`ifdef PIPE_ADD_SUB_EN
        rdy_mode = 0;
        send(128'd5, 128'd7, 1'b0, 1'b1);
        drain();
        check("sub_5_7", last_res.s, ~W'(1));
        check("sub_5_7_co", last_res.co, 0);
        send(128'd7, 128'd5, 1'b0, 1'b1);
        drain();
        check("sub_7_5", last_res.s, 128'd2);
        check("sub_7_5_co", last_res.co, 1);
`endif

        // Reset with three operations in flight, the oldest stalled at the output.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 3; i++) send(W'(i * 3), W'(i), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_vld", out_valid, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_vld", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(128'd40, 128'd2, 1'b1, 1'b0);
        drain();
        check("post_rst_sum", last_res.s, 128'd43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
